// File: rtl/bus2ip_arbiter_pkg.sv
`default_nettype none
//==============================================================================
// Package : bus2ip_arbiter_pkg
// Desc    : Shared state encodings, widths and the pointer helper for the
//           bus2ip arbiter and its round-robin pick.
// Rev     : 1.0  initial release
//==============================================================================
package bus2ip_arbiter_pkg;

    localparam int unsigned c_STATE_W = 2;
    localparam int unsigned c_CNT_W   = 3;  // holds RD_LATENCY-1 for latencies up to 7
    localparam int unsigned c_IDX_W   = 2;  // holds a grant index for up to 4 requesters

    localparam logic [c_STATE_W-1:0] c_IDLE    = 2'd0;
    localparam logic [c_STATE_W-1:0] c_ISSUE   = 2'd1;
    localparam logic [c_STATE_W-1:0] c_WAIT_RD = 2'd2;
    localparam logic [c_STATE_W-1:0] c_ACK     = 2'd3;

    function automatic logic [c_IDX_W-1:0] next_ptr(input logic [c_IDX_W-1:0] g,
                                                     input int unsigned        n);
        if ({30'd0, g} + 32'd1 >= n) begin
            return '0;
        end
        return g + 1'b1;
    endfunction

endpackage : bus2ip_arbiter_pkg
`default_nettype wire

// File: rtl/bus2ip_arbiter_rr_arbiter.sv
`default_nettype none
//==============================================================================
// Module : rr_arbiter
// Desc   : Combinational round-robin pick: first set request at or above ptr,
//          wrapping modulo NUM_REQ. Returns one-hot grant and its index.
// Rev    : 1.0  initial release
//==============================================================================
module rr_arbiter
    import bus2ip_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [c_IDX_W-1:0] ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [c_IDX_W-1:0] gnt_idx,
    output logic               any_req
);

    // d is the rotational distance from ptr; the smallest distance wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any_req = 1'b0;
        for (int d = 0; d < NUM_REQ; d++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!any_req && req[i] &&
                    (((i + NUM_REQ - int'(ptr)) % NUM_REQ) == d)) begin
                    any_req = 1'b1;
                    gnt[i]  = 1'b1;
                    gnt_idx = c_IDX_W'(i);
                end
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/bus2ip_arbiter.sv
`default_nettype none
//==============================================================================
// Module : bus2ip_arbiter
// Desc   : Round-robin sharing of one bus2ip register bus between NUM_REQ
//          requesters; one single-beat read or write per grant.
// Rev    : 1.0  initial release
//==============================================================================
module bus2ip_arbiter
    import bus2ip_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ-1:0]        we_i,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] wdata_i,
    output logic [NUM_REQ-1:0]        ack_o,
    output logic [DATA_W-1:0]         rdata_o,
    output logic                      busy_o,
    output logic [ADDR_W-1:0]         bus2ip_addr_o,
    output logic [DATA_W-1:0]         bus2ip_data_o,
    output logic                      bus2ip_rd_ce_o,
    output logic                      bus2ip_wr_ce_o,
    input  logic [DATA_W-1:0]         ip2bus_data_i
);

    generate
        if (NUM_REQ < 2 || NUM_REQ > 4 || RD_LATENCY < 1 || RD_LATENCY > 7) begin : g_param_check
            $error("bus2ip_arbiter: NUM_REQ must be 2..4 and RD_LATENCY 1..7");
        end
    endgenerate

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_next_state;
    logic [c_IDX_W-1:0]   r_ptr;
    logic [c_IDX_W-1:0]   r_gnt_idx;
    logic [c_IDX_W-1:0]   w_gnt_idx;
    logic [NUM_REQ-1:0]   r_gnt;
    logic [NUM_REQ-1:0]   w_gnt;
    logic                 w_any;
    logic                 r_we;
    logic [c_CNT_W-1:0]   r_cnt;

    logic                 w_sel_we;
    logic [ADDR_W-1:0]    w_sel_addr;
    logic [DATA_W-1:0]    w_sel_wdata;

    logic                 w_rd_ce_nxt;
    logic                 w_wr_ce_nxt;
    logic                 w_busy_nxt;
    logic [NUM_REQ-1:0]   w_ack_nxt;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req     (req_i),
        .ptr     (r_ptr),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx),
        .any_req (w_any)
    );

    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_we    = we_i[i];
                w_sel_addr  = addr_i[i*ADDR_W +: ADDR_W];
                w_sel_wdata = wdata_i[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:    if (w_any) w_next_state = c_ISSUE;
            c_ISSUE:   w_next_state = r_we ? c_ACK : c_WAIT_RD;
            c_WAIT_RD: if (r_cnt == '0) w_next_state = c_ACK;
            c_ACK:     w_next_state = c_IDLE;
            default:   w_next_state = c_IDLE;
        endcase
    end

    // Next-cycle values of the registered bus outputs, so each one lines up
    // exactly with the state it belongs to.
    always_comb begin
        w_rd_ce_nxt = 1'b0;
        w_wr_ce_nxt = 1'b0;
        w_ack_nxt   = '0;
        w_busy_nxt  = (w_next_state != c_IDLE);
        if (r_state == c_IDLE && w_next_state == c_ISSUE) begin
            w_wr_ce_nxt = w_sel_we;
            w_rd_ce_nxt = !w_sel_we;
        end
        if (w_next_state == c_ACK) begin
            w_ack_nxt = r_gnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus2ip_rd_ce_o <= 1'b0;
            bus2ip_wr_ce_o <= 1'b0;
            ack_o          <= '0;
            busy_o         <= 1'b0;
        end else begin
            bus2ip_rd_ce_o <= w_rd_ce_nxt;
            bus2ip_wr_ce_o <= w_wr_ce_nxt;
            ack_o          <= w_ack_nxt;
            busy_o         <= w_busy_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr         <= '0;
            r_gnt_idx     <= '0;
            r_gnt         <= '0;
            r_we          <= 1'b0;
            r_cnt         <= '0;
            bus2ip_addr_o <= '0;
            bus2ip_data_o <= '0;
            rdata_o       <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_any) begin
                        r_gnt_idx     <= w_gnt_idx;
                        r_gnt         <= w_gnt;
                        r_we          <= w_sel_we;
                        bus2ip_addr_o <= w_sel_addr;
                        bus2ip_data_o <= w_sel_wdata;
                    end
                end
                c_ISSUE: begin
                    r_cnt <= c_CNT_W'(RD_LATENCY - 1);
                end
                c_WAIT_RD: begin
                    if (r_cnt == '0) begin
                        rdata_o <= ip2bus_data_i;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_ACK: begin
                    r_ptr <= next_ptr(r_gnt_idx, NUM_REQ);
                end
                default: ;
            endcase
        end
    end

endmodule : bus2ip_arbiter
`default_nettype wire

// File: tb/tb_bus2ip_arbiter.sv
`default_nettype none
//==============================================================================
// Module : tb_bus2ip_arbiter
// Desc   : Self-checking bench: two arbiter configurations driven by the same
//          directed stimulus, checked against a transaction-level model.
// Rev    : 1.0  initial release
//==============================================================================
module tb_bus2ip_arbiter;

    logic        clk;
    logic        rst;
    logic [2:0]  req;
    logic [2:0]  we;
    logic [47:0] addr;
    logic [47:0] wdata;

    logic [2:0]  ack_a;
    logic [15:0] rdata_a, baddr_a, bdata_a, ip_a;
    logic        busy_a, rd_a, wr_a;
    logic [1:0]  ack_b;
    logic [15:0] rdata_b, baddr_b, bdata_b, ip_b;
    logic        busy_b, rd_b, wr_b;
    logic [3:0]  hist_a = '0;
    logic [3:0]  hist_b = '0;

    int n_checks = 0;
    int n_errors = 0;

    bus2ip_arbiter #(.NUM_REQ(3), .ADDR_W(16), .DATA_W(16), .RD_LATENCY(1)) u_dut_a (
        .clk(clk), .rst(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .ack_o(ack_a), .rdata_o(rdata_a), .busy_o(busy_a), .bus2ip_addr_o(baddr_a),
        .bus2ip_data_o(bdata_a), .bus2ip_rd_ce_o(rd_a), .bus2ip_wr_ce_o(wr_a),
        .ip2bus_data_i(ip_a)
    );

    bus2ip_arbiter #(.NUM_REQ(2), .ADDR_W(16), .DATA_W(16), .RD_LATENCY(3)) u_dut_b (
        .clk(clk), .rst(rst), .req_i(req[1:0]), .we_i(we[1:0]), .addr_i(addr[31:0]),
        .wdata_i(wdata[31:0]), .ack_o(ack_b), .rdata_o(rdata_b), .busy_o(busy_b),
        .bus2ip_addr_o(baddr_b), .bus2ip_data_o(bdata_b), .bus2ip_rd_ce_o(rd_b),
        .bus2ip_wr_ce_o(wr_b), .ip2bus_data_i(ip_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] stub_val(input logic [15:0] a);
        return a ^ 16'h1214;
    endfunction

    // Register-block stub: data is valid only RD_LATENCY cycles after rd_ce.
    always @(posedge clk) begin
        hist_a <= {hist_a[2:0], rd_a};
        hist_b <= {hist_b[2:0], rd_b};
    end
    assign ip_a = hist_a[0] ? stub_val(baddr_a) : 16'hBAD0;
    assign ip_b = hist_b[2] ? stub_val(baddr_b) : 16'hBAD0;

    // Transaction model: k = cycles since grant (0 = idle), len = cycles to ack.
    typedef struct {
        int          k;
        int          len;
        int          g;
        int          ptr;
        logic        we;
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] rdata;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t mdl_next(input mdl_t m, input int n, input int rdl,
                                      input logic [2:0] rq, input logic [2:0] wq,
                                      input logic [47:0] ad, input logic [47:0] wd);
        mdl_t r;
        bit   found;
        int   j;
        r     = m;
        found = 1'b0;
        if (m.k == 0) begin
            for (int o = 0; o < n; o++) begin
                j = (m.ptr + o) % n;
                if (!found && rq[j]) begin
                    found  = 1'b1;
                    r.k    = 1;
                    r.g    = j;
                    r.we   = wq[j];
                    r.addr = ad[j*16 +: 16];
                    r.data = wd[j*16 +: 16];
                    r.len  = wq[j] ? 2 : 2 + rdl;
                end
            end
        end else if (m.k == m.len) begin
            r.k   = 0;
            r.ptr = (m.g + 1) % n;
        end else begin
            r.k = m.k + 1;
            if (!m.we && r.k == m.len) r.rdata = stub_val(m.addr);
        end
        return r;
    endfunction

    function automatic logic [2:0] m_ack(input mdl_t m);
        return (m.k != 0 && m.k == m.len) ? 3'(1 << m.g) : 3'd0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ma <= '{default: 0};
            mb <= '{default: 0};
        end else begin
            ma <= mdl_next(ma, 3, 1, req, we, addr, wdata);
            mb <= mdl_next(mb, 2, 3, {1'b0, req[1:0]}, {1'b0, we[1:0]}, addr, wdata);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("a_ack",   32'(ack_a),   32'(m_ack(ma)));
        chk("a_busy",  32'(busy_a),  32'(ma.k != 0));
        chk("a_rd_ce", 32'(rd_a),    32'(ma.k == 1 && !ma.we));
        chk("a_wr_ce", 32'(wr_a),    32'(ma.k == 1 && ma.we));
        chk("a_addr",  32'(baddr_a), 32'(ma.addr));
        chk("a_data",  32'(bdata_a), 32'(ma.data));
        chk("a_rdata", 32'(rdata_a), 32'(ma.rdata));
        chk("b_ack",   32'(ack_b),   32'(m_ack(mb)));
        chk("b_busy",  32'(busy_b),  32'(mb.k != 0));
        chk("b_rd_ce", 32'(rd_b),    32'(mb.k == 1 && !mb.we));
        chk("b_wr_ce", 32'(wr_b),    32'(mb.k == 1 && mb.we));
        chk("b_addr",  32'(baddr_b), 32'(mb.addr));
        chk("b_data",  32'(bdata_b), 32'(mb.data));
        chk("b_rdata", 32'(rdata_b), 32'(mb.rdata));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic r, input logic w,
                           input logic [15:0] a, input logic [15:0] d);
        req[k]            = r;
        we[k]             = w;
        addr[k*16 +: 16]  = a;
        wdata[k*16 +: 16] = d;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: time limit reached, n_checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    logic [2:0] exp3 [0:11];
    logic [2:0] exp4 [0:11];
    logic [2:0] exp5a [0:5];
    logic [1:0] exp5b [0:5];

    initial begin
        exp3  = '{3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd2, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd2};
        exp4  = '{3'd0, 3'd0, 3'd4, 3'd0, 3'd0, 3'd4, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd2};
        exp5a = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0};
        exp5b = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
        rst   = 1'b1;
        req   = '0;
        we    = '0;
        addr  = '0;
        wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_ack",  32'(ack_a), 32'd0);
        chk("rst_ce",   32'({rd_a, wr_a}), 32'd0);
        chk("rst_addr", 32'(baddr_a), 32'd0);
        step();
        rst = 1'b0;
        step();

        // Single write from requester 0
        step();
        set_req(0, 1'b1, 1'b1, 16'h0010, 16'hA5A5);
        step();
        @(negedge clk);
        chk("t1_wr_ce", 32'(wr_a), 32'd1);
        chk("t1_rd_ce", 32'(rd_a), 32'd0);
        chk("t1_addr",  32'(baddr_a), 32'h0010);
        chk("t1_data",  32'(bdata_a), 32'hA5A5);
        chk("t1_ack_early", 32'(ack_a), 32'd0);
        step();
        set_req(0, 1'b0, 1'b1, 16'h0010, 16'hA5A5);
        @(negedge clk);
        chk("t1_ack",   32'(ack_a), 32'h1);
        chk("t1_wr_off", 32'(wr_a), 32'd0);
        step();
        @(negedge clk);
        chk("t1_idle_a", 32'(busy_a), 32'd0);
        chk("t1_idle_b", 32'(busy_b), 32'd0);

        // Single read from requester 1
        step();
        set_req(1, 1'b1, 1'b0, 16'h0020, 16'h0000);
        step();
        @(negedge clk);
        chk("t2_rd_ce", 32'(rd_a), 32'd1);
        chk("t2_wr_ce", 32'(wr_a), 32'd0);
        chk("t2_addr",  32'(baddr_a), 32'h0020);
        step();
        @(negedge clk);
        chk("t2_no_ack", 32'(ack_a), 32'd0);
        step();
        set_req(1, 1'b0, 1'b0, 16'h0020, 16'h0000);
        @(negedge clk);
        chk("t2_ack",   32'(ack_a), 32'h2);
        chk("t2_rdata", 32'(rdata_a), 32'h1234);
        repeat (6) step();

        // Two requesters held: strict alternation, strobes three cycles apart
        for (int c = 0; c < 12; c++) begin
            step();
            if (c == 0) begin
                set_req(0, 1'b1, 1'b1, 16'h0100, 16'h1000);
                set_req(1, 1'b1, 1'b1, 16'h0101, 16'h2000);
            end
            if (c == 11) begin
                set_req(0, 1'b0, 1'b1, 16'h0100, 16'h1000);
                set_req(1, 1'b0, 1'b1, 16'h0101, 16'h2000);
            end
            @(negedge clk);
            chk($sformatf("t3_ack_c%0d", c), 32'(ack_a), 32'(exp3[c]));
            chk($sformatf("t3_wr_c%0d", c), 32'(wr_a), 32'(c % 3 == 1));
        end
        repeat (3) step();

        // Lone requester 2 re-granted, ptr wraps, then req0 beats req1
        for (int c = 0; c < 12; c++) begin
            step();
            if (c == 0) set_req(2, 1'b1, 1'b1, 16'h0060, 16'h3333);
            if (c == 5) begin
                set_req(2, 1'b0, 1'b1, 16'h0060, 16'h3333);
                set_req(0, 1'b1, 1'b1, 16'h0070, 16'h4444);
                set_req(1, 1'b1, 1'b1, 16'h0080, 16'h5555);
            end
            if (c == 8)  set_req(0, 1'b0, 1'b1, 16'h0070, 16'h4444);
            if (c == 11) set_req(1, 1'b0, 1'b1, 16'h0080, 16'h5555);
            @(negedge clk);
            chk($sformatf("t4_ack_c%0d", c), 32'(ack_a), 32'(exp4[c]));
        end
        repeat (4) step();

        // Reset during WAIT_RD aborts; the next req0 is served first
        step();
        set_req(0, 1'b1, 1'b0, 16'h0030, 16'h0000);
        step();
        step();
        rst = 1'b1;
        set_req(1, 1'b1, 1'b0, 16'h0050, 16'h0000);
        #1;
        chk("t5_busy",  32'({busy_a, busy_b}), 32'd0);
        chk("t5_ack",   32'({ack_a, ack_b}), 32'd0);
        chk("t5_ce",    32'({rd_a, wr_a, rd_b, wr_b}), 32'd0);
        chk("t5_addr",  32'(baddr_a), 32'd0);
        chk("t5_rdata", 32'(rdata_a), 32'd0);
        step();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) step();
            if (c == 3) set_req(0, 1'b0, 1'b0, 16'h0030, 16'h0000);
            @(negedge clk);
            chk($sformatf("t5_ack_a_c%0d", c), 32'(ack_a), 32'(exp5a[c]));
            chk($sformatf("t5_ack_b_c%0d", c), 32'(ack_b), 32'(exp5b[c]));
            if (c == 3) chk("t5_rdata_a", 32'(rdata_a), 32'h1224);
        end
        set_req(1, 1'b0, 1'b0, 16'h0050, 16'h0000);
        repeat (8) step();

        // Request dropped and address changed while the strobe is on the bus
        step();
        set_req(0, 1'b1, 1'b1, 16'h0040, 16'h1111);
        step();
        set_req(0, 1'b0, 1'b1, 16'h0F0F, 16'h0000);
        @(negedge clk);
        chk("t6_addr",  32'(baddr_a), 32'h0040);
        chk("t6_data",  32'(bdata_a), 32'h1111);
        chk("t6_wr_ce", 32'(wr_a), 32'd1);
        step();
        @(negedge clk);
        chk("t6_ack",      32'(ack_a), 32'h1);
        chk("t6_addr_hold", 32'(baddr_a), 32'h0040);
        repeat (3) step();

        // All requesters reading continuously
        step();
        set_req(0, 1'b1, 1'b0, 16'h0100, 16'h0000);
        set_req(1, 1'b1, 1'b0, 16'h0200, 16'h0000);
        set_req(2, 1'b1, 1'b0, 16'h0300, 16'h0000);
        repeat (40) step();
        req = '0;
        repeat (15) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_bus2ip_arbiter
`default_nettype wire
